// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: scans two captured operands MSB-first, DIGIT bits per cycle.
// Optional build macro CMP_EARLY_EXIT_EN ends the scan on the first differing chunk.
module seq_magnitude_comparator #(
    parameter int WIDTH = 18,
    parameter int DIGIT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             signed_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             equal_o,
    output logic             a_greater_o,
    output logic             a_less_o
);
    localparam int NCHUNK = WIDTH / DIGIT;
    localparam int IDXW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    generate
        if (WIDTH % DIGIT != 0) begin : g_bad_digit
            $error("seq_magnitude_comparator: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] msb_flip;
    logic [IDXW-1:0]  idx;
    logic             decided;
    logic             gt;
    logic [DIGIT-1:0] a_chunk;
    logic [DIGIT-1:0] b_chunk;
    logic             chunk_diff;
    logic             decided_nxt;
    logic             gt_nxt;
    logic             scan_last;

    // Signed mode maps both operands to offset binary so the scan is always unsigned.
    always_comb begin
        msb_flip            = '0;
        msb_flip[WIDTH-1]   = signed_i;
    end

    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int c = 0; c < NCHUNK; c++) begin
            if (idx == IDXW'(c)) begin
                a_chunk = a_q[c*DIGIT +: DIGIT];
                b_chunk = b_q[c*DIGIT +: DIGIT];
            end
        end
    end

    assign chunk_diff  = (a_chunk != b_chunk);
    assign decided_nxt = decided | chunk_diff;
    assign gt_nxt      = decided ? gt : (a_chunk > b_chunk);
    assign scan_last   = (idx == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start_i) begin
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
`ifdef CMP_EARLY_EXIT_EN
                if (scan_last || (!decided && chunk_diff)) begin
                    state_nxt = DONE;
                end
`else
                if (scan_last) begin
                    state_nxt = DONE;
                end
`endif
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        busy_o = (state != IDLE);
        done_o = (state == DONE);
    end

    // Flags are written only on the SCAN->DONE transition, so they hold across later compares.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            idx         <= '0;
            decided     <= 1'b0;
            gt          <= 1'b0;
            equal_o     <= 1'b0;
            a_greater_o <= 1'b0;
            a_less_o    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        a_q     <= a_i ^ msb_flip;
                        b_q     <= b_i ^ msb_flip;
                        idx     <= LAST_IDX;
                        decided <= 1'b0;
                        gt      <= 1'b0;
                    end
                end
                SCAN: begin
                    decided <= decided_nxt;
                    gt      <= gt_nxt;
                    idx     <= idx - IDXW'(1);
                    if (state_nxt == DONE) begin
                        equal_o     <= !decided_nxt;
                        a_greater_o <= decided_nxt & gt_nxt;
                        a_less_o    <= decided_nxt & !gt_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
